// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam int XLEN     = 32;
  localparam int MDU_ITER = 32;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the core (master) and the multiply/divide unit (slave).
interface mdu_if #(
  parameter int XLEN       = mdu_pkg::XLEN,
  parameter int REG_ADDR_W = 5
);
  logic                  start;
  logic [2:0]            op;
  logic [XLEN-1:0]       rs1_val;
  logic [XLEN-1:0]       rs2_val;
  logic [REG_ADDR_W-1:0] rd_in;
  logic                  busy;
  logic                  done;
  logic [XLEN-1:0]       result;
  logic [REG_ADDR_W-1:0] rd_out;
  logic                  we;
  logic                  illegal;

  modport master (
    output start, op, rs1_val, rs2_val, rd_in,
    input  busy, done, result, rd_out, we, illegal
  );

  modport slave (
    input  start, op, rs1_val, rs2_val, rd_in,
    output busy, done, result, rd_out, we, illegal
  );
endinterface

// File: rtl/mdu_abs_neg.sv
// Combinational conditional two's-complement negate of a W-bit value.
module mdu_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);
  assign res = neg ? (~val + W'(1)) : val;
endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M unit: shift-add multiply and restoring divide, one bit per cycle.
// The divider is built only when MDU_DIV_EN is defined; otherwise divide ops complete as illegal.
module mdu_iterative #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);
  import mdu_pkg::*;

  localparam int CNT_W = $clog2(MDU_ITER);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e            state, state_nxt;
  mdu_op_e               op_in, op_q;
  logic [2*XLEN-1:0]     acc, prod_fix;
  logic [XLEN-1:0]       mcand, a_mag, b_mag, final_val, result_q;
  logic [XLEN:0]         mul_sum;
  logic [REG_ADDR_W-1:0] rd_q, rd_out_q;
  logic [CNT_W-1:0]      cnt;
  logic                  neg_lo, neg_rem, illegal_q;
  logic                  sign_a, sign_b, accept, calc_last, done_w;

  assign op_in     = mdu_op_e'(bus.op);
  assign sign_a    = bus.rs1_val[XLEN-1] && (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign sign_b    = bus.rs2_val[XLEN-1] && (op_in inside {OP_MULH, OP_DIV, OP_REM});
  assign accept    = bus.start && (state == IDLE || state == DONE);
  assign calc_last = (cnt == CNT_W'(MDU_ITER - 1));

  mdu_abs_neg #(.W(XLEN))   u_mag_a  (.val(bus.rs1_val), .neg(sign_a), .res(a_mag));
  mdu_abs_neg #(.W(XLEN))   u_mag_b  (.val(bus.rs2_val), .neg(sign_b), .res(b_mag));
  mdu_abs_neg #(.W(2*XLEN)) u_fix_lo (.val(acc),         .neg(neg_lo), .res(prod_fix));

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);

`ifdef MDU_DIV_EN
  logic              div_zero, div_ovf;
  logic [XLEN:0]     div_sh, div_diff;
  logic [XLEN-1:0]   rem_fix;
  logic [2*XLEN-1:0] div_next;

  assign div_zero = (bus.rs2_val == '0);
  assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
                    (bus.rs1_val == MIN_NEG) && (bus.rs2_val == '1);

  // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract the divisor.
  assign div_sh   = acc[2*XLEN-1:XLEN-1];
  assign div_diff = div_sh - {1'b0, mcand};
  assign div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  mdu_abs_neg #(.W(XLEN)) u_fix_rem (.val(acc[2*XLEN-1:XLEN]), .neg(neg_rem), .res(rem_fix));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (bus.start) begin
          if (!bus.op[2]) begin
            state_nxt = CALC;
          end else begin
`ifdef MDU_DIV_EN
            state_nxt = (div_zero || div_ovf) ? FINAL : CALC;
`else
            state_nxt = DONE;
`endif
          end
        end
      end
      CALC:    if (calc_last) state_nxt = FINAL;
      FINAL:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    final_val = prod_fix[XLEN-1:0];
    if (!op_q[2] && op_q[1:0] != 2'b00) final_val = prod_fix[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
    if (op_q[2] && op_q[1]) final_val = rem_fix;
`endif
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op_in;
      rd_q    <= bus.rd_in;
      cnt     <= '0;
      acc     <= {{XLEN{1'b0}}, b_mag};
      mcand   <= a_mag;
      neg_lo  <= sign_a ^ sign_b;
      neg_rem <= 1'b0;
`ifdef MDU_DIV_EN
      if (bus.op[2]) begin
        // Special cases preload the final quotient/remainder so FINAL passes them through.
        if (div_zero) begin
          acc    <= {bus.rs1_val, DIV0_QUOT};
          neg_lo <= 1'b0;
        end else if (div_ovf) begin
          acc    <= {{XLEN{1'b0}}, MIN_NEG};
          neg_lo <= 1'b0;
        end else begin
          acc     <= {{XLEN{1'b0}}, a_mag};
          mcand   <= b_mag;
          neg_rem <= sign_a;
        end
      end
`endif
    end else if (state == CALC) begin
      cnt <= cnt + CNT_W'(1);
`ifdef MDU_DIV_EN
      acc <= op_q[2] ? div_next : {mul_sum, acc[XLEN-1:1]};
`else
      acc <= {mul_sum, acc[XLEN-1:1]};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      rd_out_q  <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
`ifdef MDU_DIV_EN
      illegal_q <= 1'b0;
`else
      illegal_q <= bus.op[2];
      if (bus.op[2]) result_q <= '0;
`endif
    end else if (state == FINAL) begin
      result_q <= final_val;
      rd_out_q <= rd_q;
    end
  end

  assign done_w      = (state == DONE);
  assign bus.busy    = (state == CALC) || (state == FINAL);
  assign bus.done    = done_w;
  assign bus.illegal = done_w && illegal_q;
  assign bus.we      = done_w && !illegal_q && (rd_out_q != '0);
  assign bus.result  = result_q;
  assign bus.rd_out  = rd_out_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative; divide vectors run when MDU_DIV_EN is defined.
module tb_mdu_iterative;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  mdu_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  mdu_iterative #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [7:0]  lat;
  } vec_t;

  // Called 1 time unit after a rising edge; returns 1 time unit after the edge that sampled start.
  task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
    bus.op      = op;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in   = rd;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat, output int busy_bad,
                           output logic [31:0] res, output logic [4:0] rdo,
                           output logic we_o, output logic ill_o);
    int c;
    lat = -1; busy_bad = 0; res = '0; rdo = '0; we_o = 1'b0; ill_o = 1'b0;
    c = 1;
    while (c <= budget && lat < 0) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = c; res = bus.result; rdo = bus.rd_out; we_o = bus.we; ill_o = bus.illegal;
        if (bus.busy !== 1'b0) busy_bad++;
      end else if (bus.busy !== 1'b1) begin
        busy_bad++;
      end
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.we, bus.illegal} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.we, bus.illegal});
    end
    checks++;
    if ({bus.result, bus.rd_out} !== 37'h0) begin
      fails++;
      $display("FAIL reset_data: got %h/%h want 0/0", bus.result, bus.rd_out);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul();
    vec_t tbl [9];
    int lat, bb;
    logic [31:0] res;
    logic [4:0] rdo;
    logic we_o, ill_o;
    tbl[0] = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 8'd34};
    tbl[1] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 8'd34};
    tbl[2] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'd34};
    tbl[3] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd34};
    tbl[4] = '{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 8'd34};
    tbl[5] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 8'd34};
    tbl[6] = '{3'b011, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 8'd34};
    tbl[7] = '{3'b001, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 8'd34};
    tbl[8] = '{3'b010, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 8'd34};
    for (int i = 0; i < 9; i++) begin
      drive_start(tbl[i].op, tbl[i].a, tbl[i].b, 5'(5 + i));
      wait_done(60, lat, bb, res, rdo, we_o, ill_o);
      checks++;
      if (lat != int'(tbl[i].lat)) begin
        fails++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, tbl[i].lat);
      end
      checks++;
      if (res !== tbl[i].exp) begin
        fails++; $display("FAIL mul[%0d] result: got %h want %h", i, res, tbl[i].exp);
      end
      checks++;
      if ({rdo, we_o, ill_o} !== {5'(5 + i), 1'b1, 1'b0}) begin
        fails++; $display("FAIL mul[%0d] rd/we/illegal: got %h/%b/%b want %h/1/0", i, rdo, we_o, ill_o, 5'(5 + i));
      end
      checks++;
      if (bb != 0) begin
        fails++; $display("FAIL mul[%0d] busy: got %0d bad cycles want 0", i, bb);
      end
      if (i == 0) begin
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
          fails++; $display("FAIL done_pulse: got %b want 0", bus.done);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div();
    vec_t tbl [12];
    int lat, bb;
    logic [31:0] res;
    logic [4:0] rdo;
    logic we_o, ill_o;
    tbl[0]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 8'd34};
    tbl[1]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 8'd34};
    tbl[2]  = '{3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 8'd34};
    tbl[3]  = '{3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 8'd34};
    tbl[4]  = '{3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 8'd2};
    tbl[5]  = '{3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 8'd2};
    tbl[6]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 8'd2};
    tbl[7]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 8'd2};
    tbl[8]  = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 8'd34};
    tbl[9]  = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 8'd34};
    tbl[10] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 8'd34};
    tbl[11] = '{3'b110, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 8'd2};
    for (int i = 0; i < 12; i++) begin
      drive_start(tbl[i].op, tbl[i].a, tbl[i].b, 5'(10 + i));
      wait_done(60, lat, bb, res, rdo, we_o, ill_o);
      checks++;
      if (lat != int'(tbl[i].lat)) begin
        fails++; $display("FAIL div[%0d] latency: got %0d want %0d", i, lat, tbl[i].lat);
      end
      checks++;
      if (res !== tbl[i].exp) begin
        fails++; $display("FAIL div[%0d] result: got %h want %h", i, res, tbl[i].exp);
      end
      checks++;
      if ({rdo, we_o, ill_o} !== {5'(10 + i), 1'b1, 1'b0}) begin
        fails++; $display("FAIL div[%0d] rd/we/illegal: got %h/%b/%b want %h/1/0", i, rdo, we_o, ill_o, 5'(10 + i));
      end
      checks++;
      if (bb != 0) begin
        fails++; $display("FAIL div[%0d] busy: got %0d bad cycles want 0", i, bb);
      end
    end
  endtask
`else
  task automatic test_illegal();
    vec_t tbl [3];
    int lat, bb;
    logic [31:0] res;
    logic [4:0] rdo;
    logic we_o, ill_o;
    tbl[0] = '{3'b100, 32'h0000_0005, 32'h0000_0003, 32'h0, 8'd1};
    tbl[1] = '{3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0, 8'd1};
    tbl[2] = '{3'b101, 32'h0000_0000, 32'h0000_0000, 32'h0, 8'd1};
    for (int i = 0; i < 3; i++) begin
      drive_start(tbl[i].op, tbl[i].a, tbl[i].b, 5'(3 + i));
      wait_done(60, lat, bb, res, rdo, we_o, ill_o);
      checks++;
      if (lat != int'(tbl[i].lat)) begin
        fails++; $display("FAIL illegal[%0d] latency: got %0d want %0d", i, lat, tbl[i].lat);
      end
      checks++;
      if (res !== tbl[i].exp) begin
        fails++; $display("FAIL illegal[%0d] result: got %h want %h", i, res, tbl[i].exp);
      end
      checks++;
      if ({we_o, ill_o} !== 2'b01) begin
        fails++; $display("FAIL illegal[%0d] we/illegal: got %b/%b want 0/1", i, we_o, ill_o);
      end
      checks++;
      if (bb != 0) begin
        fails++; $display("FAIL illegal[%0d] busy: got %0d bad cycles want 0", i, bb);
      end
    end
  endtask
`endif

  task automatic test_ignore_start();
    int cyc, nd, dl;
    logic [31:0] res;
    logic [4:0] rdo;
    nd = 0; dl = -1; res = '0; rdo = '0;
    drive_start(3'b000, 32'd3, 32'd5, 5'd2);
    cyc = 1;
    while (cyc <= 80) begin
      if (cyc == 5) begin
        bus.start = 1'b1; bus.rs1_val = 32'd100; bus.rs2_val = 32'd100; bus.rd_in = 5'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done === 1'b1) begin
        nd++;
        if (dl < 0) begin dl = cyc; res = bus.result; rdo = bus.rd_out; end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.start = 1'b0;
    checks++;
    if (nd != 1 || dl != 34) begin
      fails++; $display("FAIL ignore_start timing: got %0d dones at %0d want 1 at 34", nd, dl);
    end
    checks++;
    if ({res, rdo} !== {32'd15, 5'd2}) begin
      fails++; $display("FAIL ignore_start data: got %h/%h want 0000000f/02", res, rdo);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, d1, d2;
    logic [31:0] r1, r2;
    logic [4:0] rdo2;
    d1 = -1; d2 = -1; r1 = '0; r2 = '0; rdo2 = '0;
    drive_start(3'b000, 32'd6, 32'd7, 5'd3);
    cyc = 1;
    while (cyc <= 100 && d2 < 0) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (d1 < 0) begin
          d1 = cyc; r1 = bus.result;
          bus.op = 3'b000; bus.rs1_val = 32'hFFFF_FFFE; bus.rs2_val = 32'd3; bus.rd_in = 5'd4;
          bus.start = 1'b1;
        end else begin
          d2 = cyc; r2 = bus.result; rdo2 = bus.rd_out;
        end
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc++;
    end
    checks++;
    if (d1 != 34 || d2 != 68) begin
      fails++; $display("FAIL back_to_back timing: got %0d/%0d want 34/68", d1, d2);
    end
    checks++;
    if ({r1, r2, rdo2} !== {32'd42, 32'hFFFF_FFFA, 5'd4}) begin
      fails++; $display("FAIL back_to_back data: got %h/%h/%h want 0000002a/fffffffa/04", r1, r2, rdo2);
    end
  endtask

  task automatic test_rd_zero();
    int lat, bb;
    logic [31:0] res;
    logic [4:0] rdo;
    logic we_o, ill_o;
    drive_start(3'b000, 32'd2, 32'd3, 5'd0);
    wait_done(60, lat, bb, res, rdo, we_o, ill_o);
    checks++;
    if (lat != 34 || res !== 32'd6) begin
      fails++; $display("FAIL rd_zero done: got lat %0d result %h want 34/00000006", lat, res);
    end
    checks++;
    if ({rdo, we_o, ill_o} !== 7'b0) begin
      fails++; $display("FAIL rd_zero we: got %h/%b/%b want 00/0/0", rdo, we_o, ill_o);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, nd;
    drive_start(3'b000, 32'd9, 32'd9, 5'd7);
    cyc = 1;
    while (cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      fails++; $display("FAIL reset_mid busy/done: got %b/%b want 0/0", bus.busy, bus.done);
    end
    checks++;
    if ({bus.result, bus.rd_out} !== 37'h0) begin
      fails++; $display("FAIL reset_mid data: got %h/%h want 0/0", bus.result, bus.rd_out);
    end
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done !== 1'b0) nd++;
    end
    checks++;
    if (nd != 0) begin
      fails++; $display("FAIL reset_mid no_done: got %0d done cycles want 0", nd);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 3'b000;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.rd_in   = '0;
    test_reset();
`ifdef MDU_DIV_EN
    test_div();
`else
    test_illegal();
`endif
    test_mul();
    test_ignore_start();
    test_back_to_back();
    test_rd_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Multi-cycle RV32M multiply/divide unit. It sits between the register file read ports and its write port.
- It consumes the rd1/rd2 operand values and the decoded rd, then returns a result, destination and write enable for writeback.
- busy stalls the single-cycle core (PC hold) while an M-extension op is in flight.
- Shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- XLEN, 32: operand/result width.
- REG_ADDR_W, 5: register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request; sampled only when not busy
- op  in  3  funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_val  in  XLEN  operand A (register file rd1)
- rs2_val  in  XLEN  operand B (register file rd2)
- rd_in  in  REG_ADDR_W  destination index
- busy  out  1  op in flight; core must stall
- done  out  1  one-cycle pulse; result/rd_out valid
- result  out  XLEN  writeback data
- rd_out  out  REG_ADDR_W  destination for writeback
- we  out  1  done && rd_out != 0
- illegal  out  1  pulse with done when op unsupported

Behaviour:
- Reset: all outputs 0; state IDLE. rst mid-operation aborts: next cycle IDLE, no done issued.
- States:
  - IDLE: on start, latch op/rd_in/operands and signs; take magnitudes per op signedness.
    - MULH: both signed. MULHSU: A signed, B unsigned. MULHU/DIVU/REMU: unsigned.
    - Go to CALC with counter=0, or to FINAL on a special divide case.
  - CALC: one multiply/divide bit per cycle; 32 cycles; counter 0..31; exits to FINAL at 31.
  - FINAL: apply sign correction and select output, then register result.
    - Multiply: 64-bit product negated if signA^signB. MUL takes low word; MULH/MULHSU/MULHU take high word.
    - Divide: quotient negated if signA^signB; remainder takes signA.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start in cycle N gives done in cycle N+34 (IDLE→32×CALC→FINAL→DONE).
- Special divide cases skip CALC, so done occurs at N+2:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - DIV of 0x80000000 by 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- busy is 1 in CALC and FINAL, and 0 in IDLE and DONE.
- start is accepted in DONE as well as IDLE: back-to-back ops, no bubble. The new op's done falls at its own N+34.
- start while busy is ignored and the latched operands are unaffected.
- Operands are captured at start; later changes on rs1_val/rs2_val have no effect.
- result/rd_out hold their last value until the next FINAL.

Optional Feature:
- Macro MDU_DIV_EN.
- Defined: DIV/DIVU/REM/REMU are implemented as above.
- Undefined:
  - No divider datapath is synthesised.
  - Start with op[2]=1 goes IDLE→DONE, so done occurs at N+1 with illegal=1, result=0 and we=0.
  - Multiply ops are unchanged; illegal is always 0 for multiply ops.

Decomposition:
- Shared package mdu_pkg contains:
  - mdu_op_e enum (the 8 funct3 codes)
  - mdu_state_e (IDLE, CALC, FINAL, DONE)
  - localparams XLEN=32, MDU_ITER=32
  - DIV0_QUOT=32'hFFFF_FFFF
- One natural sub-module: mdu_abs_neg, a combinational conditional two's-complement negate, parameterised by width. It is instantiated for operand magnitudes (32-bit) and for the result fix-up (64-bit product / 32-bit quotient and remainder).

Test Plan:
- MUL 7 × 0xFFFFFFFD, rd_in=5, start at N → done at N+34, result 0xFFFFFFEB, rd_out=5, we=1; busy high N+1..N+33.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each done at N+34.
- DIV 5/0 → 0xFFFFFFFF at N+2; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Control scenarios:
  - start pulsed at N+5 mid-op → ignored, single done at N+34.
  - start during the DONE cycle → second done 34 cycles later.
  - rst at N+10 → busy=0 at N+11 and no done ever.
  - rd_in=0 → done=1, we=0.
- MDU_DIV_EN undefined: DIV start at N → done and illegal at N+1, result 0, we=0; MUL still gives correct results.
